// File: rtl/lcd_arbiter_pkg.sv
// Shared types and constants for the LCD arbiter: FSM encoding, LCD op codes,
// default wait-state timeout and the registered command payload.
package lcd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_RDY  = 2'd2
  } state_t;

  localparam logic [1:0] OP_WRITE_DATA = 2'd1;
  localparam logic [1:0] OP_COMMAND    = 2'd3;

  localparam int unsigned TIMEOUT_DEFAULT = 50000;
  localparam int unsigned CNT_W           = 16;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ops;
  } lcd_cmd_t;

endpackage

// File: rtl/lcd_arbiter_rr_pick.sv
// Round-robin winner selection; a locked, still-requesting last winner keeps the bus.
module lcd_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDX_W-1:0]   idx_c,
  output logic               vld_c
);

  int unsigned cand;

  always_comb begin
    grant_c = '0;
    idx_c   = last;
    vld_c   = 1'b0;
    cand    = 0;
    if (req[last] && lock[last]) begin
      vld_c = 1'b1;
    end else begin
      // Search starts one past the last winner and wraps, so last is checked last.
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
        cand = (32'(last) + i) % NUM_REQ;
        if (!vld_c && req[IDX_W'(cand)]) begin
          vld_c = 1'b1;
          idx_c = IDX_W'(cand);
        end
      end
    end
    if (vld_c) grant_c[idx_c] = 1'b1;
  end

endmodule

// File: rtl/lcd_arbiter.sv
// Arbitrates NUM_REQ requesters onto a single LCD driver handshake with a
// per-wait-state timeout; the driver itself lives outside this block.
module lcd_arbiter
  import lcd_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [8*NUM_REQ-1:0] data_i,
  input  logic [2*NUM_REQ-1:0] ops_i,
  input  logic [NUM_REQ-1:0]   lock_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic                 err_o,
  output logic [7:0]           lcd_data_o,
  output logic [1:0]           lcd_ops_o,
  output logic                 lcd_enb_o,
  output logic                 lcd_rst_o,
  input  logic                 lcd_rdy_i
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_t             state;
  lcd_cmd_t           cmd_q;
  logic [IDX_W-1:0]   last_winner;
  logic [CNT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic               timeout_c;
  logic [NUM_REQ-1:0] pick_gnt_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic               pick_vld_c;

  lcd_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req     (req_i),
    .lock    (lock_i),
    .last    (last_winner),
    .grant_c (pick_gnt_c),
    .idx_c   (pick_idx_c),
    .vld_c   (pick_vld_c)
  );

  assign cnt_inc_c  = wait_cnt + CNT_W'(1);
  assign timeout_c  = (cnt_inc_c == CNT_W'(TIMEOUT_CYCLES));
  assign lcd_data_o = cmd_q.data;
  assign lcd_ops_o  = cmd_q.ops;

  always_ff @(posedge clk_i) begin
    lcd_rst_o <= rst_i;
    if (rst_i) begin
      state       <= ST_IDLE;
      cmd_q       <= '0;
      lcd_enb_o   <= 1'b0;
      gnt_o       <= '0;
      done_o      <= '0;
      err_o       <= 1'b0;
      wait_cnt    <= '0;
      last_winner <= IDX_W'(NUM_REQ - 1);
    end else begin
      done_o <= '0;
      unique case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (lcd_rdy_i && pick_vld_c) begin
            cmd_q.data  <= data_i[{pick_idx_c, 3'b000} +: 8];
            cmd_q.ops   <= ops_i[{pick_idx_c, 1'b0} +: 2];
            lcd_enb_o   <= 1'b1;
            gnt_o       <= pick_gnt_c;
            last_winner <= pick_idx_c;
            state       <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY, ST_WAIT_RDY: begin
          wait_cnt <= cnt_inc_c;
          // Timeout wins over the handshake so a stuck driver always releases the bus.
          if (timeout_c) begin
            err_o     <= 1'b1;
            lcd_enb_o <= 1'b0;
            done_o    <= gnt_o;
            gnt_o     <= '0;
            wait_cnt  <= '0;
            state     <= ST_IDLE;
          end else if (state == ST_WAIT_BUSY && !lcd_rdy_i) begin
            lcd_enb_o <= 1'b0;
            wait_cnt  <= '0;
            state     <= ST_WAIT_RDY;
          end else if (state == ST_WAIT_RDY && lcd_rdy_i) begin
            done_o   <= gnt_o;
            gnt_o    <= '0;
            wait_cnt <= '0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
